fir_filter_core: RTL and testbench
==================================

# fir_filter_core

8-tap direct-form FIR filter with a single time-shared multiply-accumulate unit. Each sample is accepted on a one-cycle `input_data_flag` strobe, and the block returns one full-precision filtered result per accepted sample. It sits between a sample source that produces at most one sample every 10 clocks and a downstream consumer that samples `output_data` when `output_data_flag` is high.

## Interface
Parameters:
- `DATA_W`, 8: input sample width, signed two's complement.
- `COEF_W`, 8: coefficient width, signed two's complement.
- `C0`..`C7`, 1,2,3,4,4,3,2,1: tap coefficients. `C0` multiplies the newest sample.
- `OUT_W`, derived, `DATA_W+COEF_W+3` (19): output and accumulator width. Not overridable.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `input_data`, input, DATA_W: new sample, signed.
- `input_data_flag`, input, 1: sample-valid strobe, one cycle per sample.
- `output_data`, output, OUT_W: filter result, signed. Held until the next result.
- `output_data_flag`, output, 1: one-cycle pulse; `output_data` is new this cycle.
- `busy`, output, 1: high while a computation is in progress. Strobes are ignored while high.

## Operation
- Delay line `x[0..7]` of DATA_W-bit signed registers. `x[0]` is the newest sample.
- Result: y = sum over k=0..7 of `x[k]*Ck`. All products are signed, sign-extended to OUT_W, and accumulated exactly; no rounding or saturation is needed at this width.
- FSM states:
  - IDLE: `busy`=0. On `input_data_flag`=1, shift the delay line (`x[k]`<=`x[k-1]`, `x[0]`<=`input_data`), clear the accumulator and tap index, then go to MAC.
  - MAC: each cycle, acc += `x[idx]*C[idx]` and idx++. After idx=7 has been accumulated, go to DONE.
  - DONE: `output_data`<=acc, `output_data_flag`<=1 for exactly one cycle, then return to IDLE.
- `input_data_flag` in MAC or DONE is ignored. The sample is dropped, the delay line is unchanged, and the flag is not queued.
- A flag held high for several cycles in IDLE counts as one sample, taken on the first edge. The remaining high cycles fall in MAC and are ignored.
- Reset (`rst_n`=0, at any time, asynchronously):
  - Delay line, accumulator and idx cleared to 0.
  - `output_data`=0, `output_data_flag`=0, `busy`=0, state IDLE.
  - A computation in flight is discarded and produces no flag after reset is released.

## Timing
- Edge E0: strobe sampled in IDLE; sample captured.
- Edges E1..E8: taps 0..7 accumulated. `busy`=1 from after E0 until after E9.
- Edge E9: `output_data` updated and `output_data_flag` set. The flag is high for the E9–E10 cycle only.
- Latency: 9 clocks from the capture edge to the flag. The earliest next accepted strobe is at E10.
- Minimum sample spacing: 10 clocks.
- `busy` and `output_data_flag` are registered outputs; there are no combinational input-to-output paths.

## Test plan
- Reset behaviour: hold `rst_n`=0 for 3 cycles, then release with no strobes. Required: `output_data`=0, `output_data_flag`=0 and `busy`=0 throughout.
- Two-sample sequence: after reset, strobe 17, then strobe 18 ten cycles later. Required: first result 17 with its flag exactly 9 clocks after capture; second result 18+2·17=52. Also check flag width is 1 cycle and `output_data` is held between results.
- Impulse response: strobe 1, then seven strobes of 0 at 10-cycle spacing. Required: results 1,2,3,4,4,3,2,1, then 0 on a ninth strobe of 0.
- Signed extremes: eight strobes of -128, then eight of 127. Required: after the eighth, -2560; after the sixteenth, 2540. Intermediate results follow the partial sums exactly.
- Strobe while busy: strobe 17, then 99 four cycles later. Required: 99 is ignored and the result is 17. A following strobe of 18 yields 52, confirming the delay line was not shifted by 99.
- Reset mid-operation: strobe 50, then assert `rst_n`=0 at E5 and release. Required: no flag and `output_data`=0. A following strobe of 10 yields 10, confirming the delay line was cleared.

Source files
------------

// File: rtl/fir_filter_core.sv
// 8-tap direct-form FIR filter built around one time-shared multiply-accumulate unit.
// One sample in per input_data_flag strobe, one full-precision result out 9 clocks later.
module fir_filter_core #(
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int C0 = 1,
  parameter int C1 = 2,
  parameter int C2 = 3,
  parameter int C3 = 4,
  parameter int C4 = 4,
  parameter int C5 = 3,
  parameter int C6 = 2,
  parameter int C7 = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic signed [DATA_W-1:0]             input_data,
  input  logic                                 input_data_flag,
  output logic signed [DATA_W+COEF_W+3-1:0]    output_data,
  output logic                                 output_data_flag,
  output logic                                 busy
);

  localparam int OUT_W  = DATA_W + COEF_W + 3;
  localparam int PROD_W = DATA_W + COEF_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic signed [DATA_W-1:0]  x_q [8];
  logic signed [OUT_W-1:0]   acc_q;
  logic        [2:0]         idx_q;
  logic signed [OUT_W-1:0]   out_q;
  logic                      flag_q;
  logic                      busy_q;

  logic signed [COEF_W-1:0]  coef_s;
  logic signed [PROD_W-1:0]  prod_s;
  logic signed [OUT_W-1:0]   acc_d;

  function automatic logic signed [COEF_W-1:0] coef_at(input logic [2:0] k);
    case (k)
      3'd0:    coef_at = COEF_W'(C0);
      3'd1:    coef_at = COEF_W'(C1);
      3'd2:    coef_at = COEF_W'(C2);
      3'd3:    coef_at = COEF_W'(C3);
      3'd4:    coef_at = COEF_W'(C4);
      3'd5:    coef_at = COEF_W'(C5);
      3'd6:    coef_at = COEF_W'(C6);
      3'd7:    coef_at = COEF_W'(C7);
      default: coef_at = '0;
    endcase
  endfunction

  // Current tap product, sign-extended and added to the running sum.
  always_comb begin
    coef_s = coef_at(idx_q);
    prod_s = x_q[idx_q] * coef_s;
    acc_d  = acc_q + {{(OUT_W-PROD_W){prod_s[PROD_W-1]}}, prod_s};
  end

  // Sequencer: capture sample, walk the eight taps, publish the result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      for (int k = 0; k < 8; k++) x_q[k] <= '0;
      acc_q   <= '0;
      idx_q   <= 3'd0;
      out_q   <= '0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          flag_q <= 1'b0;
          if (input_data_flag) begin
            for (int k = 7; k > 0; k--) x_q[k] <= x_q[k-1];
            x_q[0]  <= input_data;
            acc_q   <= '0;
            idx_q   <= 3'd0;
            busy_q  <= 1'b1;
            state_q <= ST_MAC;
          end else begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        ST_MAC: begin
          acc_q <= acc_d;
          idx_q <= idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_q <= ST_DONE;
          end else begin
            state_q <= ST_MAC;
          end
        end
        ST_DONE: begin
          out_q   <= acc_q;
          flag_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
          flag_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign output_data      = out_q;
  assign output_data_flag = flag_q;
  assign busy             = busy_q;

endmodule

// File: tb/tb_fir_filter_core.sv
// Self-checking bench for fir_filter_core: directed plan items plus random samples,
// checked against a delay-line/dot-product reference model.
module tb_fir_filter_core;

  logic               clk;
  logic               rst_n;
  logic signed [7:0]  input_data;
  logic               input_data_flag;
  logic signed [18:0] output_data;
  logic               output_data_flag;
  logic               busy;

  int n_cmp;
  int n_err;
  int hist [8];
  int coefs [8] = '{1, 2, 3, 4, 4, 3, 2, 1};

  fir_filter_core dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .input_data       (input_data),
    .input_data_flag  (input_data_flag),
    .output_data      (output_data),
    .output_data_flag (output_data_flag),
    .busy             (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_push(input int v);
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
  endfunction

  function automatic int model_y();
    int s = 0;
    for (int k = 0; k < 8; k++) s += hist[k] * coefs[k];
    return s;
  endfunction

  // Strobe v (held for 'hold' cycles); optionally pulse busy_v at cycle busy_at.
  task automatic send(input int v, input int hold, input int busy_at, input int busy_v);
    int lat;
    int prev;
    lat = 0;
    @(negedge clk);
    input_data = 8'(v);
    input_data_flag = 1'b1;
    @(posedge clk);
    model_push(v);
    #1;
    for (int c = 1; c <= 20 && lat == 0; c++) begin
      if (c >= hold) input_data_flag = 1'b0;
      if (c == busy_at) begin
        input_data = 8'(busy_v);
        input_data_flag = 1'b1;
      end
      @(posedge clk);
      #1;
      if (c == 4) check("busy_mid", int'(busy), 1);
      if (output_data_flag) lat = c;
    end
    input_data_flag = 1'b0;
    check("latency", lat, 9);
    check("busy_at_flag", int'(busy), 0);
    check("result", int'(output_data), model_y());
    prev = int'(output_data);
    @(posedge clk);
    #1;
    check("flag_width", int'(output_data_flag), 0);
    check("held", int'(output_data), prev);
  endtask

  initial begin
    int flags;
    n_cmp = 0;
    n_err = 0;
    model_clear();
    rst_n = 1'b0;
    input_data = 8'sd0;
    input_data_flag = 1'b0;

    // Reset behaviour
    repeat (3) begin
      @(negedge clk);
      check("rst_out", int'(output_data), 0);
      check("rst_flag", int'(output_data_flag), 0);
      check("rst_busy", int'(busy), 0);
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_flag", int'(output_data_flag), 0);
      check("idle_busy", int'(busy), 0);
      check("idle_out", int'(output_data), 0);
    end

    // Two-sample sequence
    send(17, 1, 0, 0);
    check("first_17", int'(output_data), 17);
    send(18, 1, 0, 0);
    check("second_52", int'(output_data), 52);

    // Impulse response
    model_clear();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 1, 0, 0);
    for (int i = 0; i < 8; i++) send(0, 1, 0, 0);

    // Signed extremes
    for (int i = 0; i < 8; i++) send(-128, 1, 0, 0);
    check("neg_ext", int'(output_data), -2560);
    for (int i = 0; i < 8; i++) send(127, 1, 0, 0);
    check("pos_ext", int'(output_data), 2540);

    // Strobe while busy
    model_clear();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(17, 1, 4, 99);
    check("busy_drop", int'(output_data), 17);
    send(18, 1, 0, 0);
    check("busy_noshift", int'(output_data), 52);

    // Flag held for several cycles counts once
    send(5, 4, 0, 0);
    send(-3, 1, 0, 0);

    // Reset mid-operation
    @(negedge clk);
    input_data = 8'sd50;
    input_data_flag = 1'b1;
    @(posedge clk);
    #1;
    input_data_flag = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    @(negedge clk);
    check("midrst_busy", int'(busy), 0);
    check("midrst_out", int'(output_data), 0);
    @(negedge clk);
    rst_n = 1'b1;
    flags = 0;
    repeat (12) begin
      @(negedge clk);
      if (output_data_flag) flags++;
    end
    check("midrst_noflag", flags, 0);
    check("midrst_out0", int'(output_data), 0);
    send(10, 1, 0, 0);
    check("after_rst_10", int'(output_data), 10);

    // Random samples, with occasional ignored strobes while busy
    for (int i = 0; i < 30; i++) begin
      int v;
      int ba;
      v = int'($signed(8'($urandom_range(0, 255))));
      ba = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 8)) : 0;
      send(v, 1, ba, int'($urandom_range(0, 255)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
